decode_stage_nw: RTL and testbench

DECODE_STAGE_NW -- requirements
Module: decode_stage_nw

---
 rtl/decode_pkg.sv | 38 +++
 rtl/decode_stage_nw_uop.sv | 41 ++++
 rtl/decode_stage_nw.sv | 105 ++++++++++
 tb/tb_decode_stage_nw.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: shared uop format, opcode map, ALU op codes and opcode classification for the decode stage.
// Field layout is fixed to the 16-bit ISA with 8 architectural registers:
//   [15:12] opcode  [11:9] ra  [8:6] rb  [5:3] rc  [2] cmp  [1:0] cz
//   I-type imm = sext([5:0]); J-type imm = sext([8:0]) (LHI: [8:0] << 7).
package decode_pkg;
  localparam int ILEN = 16;
  localparam int REG_W = 3;
  localparam logic [3:0] OP_ADI = 4'b0000, OP_ADD = 4'b0001, OP_NDU = 4'b0010, OP_LHI = 4'b0011,
                         OP_LW  = 4'b0100, OP_SW  = 4'b0101, OP_LM  = 4'b0110, OP_SM  = 4'b0111,
                         OP_BEQ = 4'b1000, OP_BLT = 4'b1001, OP_JAL = 4'b1100, OP_JLR = 4'b1101,
                         OP_JRI = 4'b1111;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_NAND = 3'd1, ALU_SUB = 3'd2, ALU_SLT = 3'd3, ALU_PASS = 3'd4;
  typedef enum logic [1:0] {CLS_NONE, CLS_R, CLS_I, CLS_J} cls_t;
  typedef struct packed {
    logic [3:0]       opcode;
    logic [REG_W-1:0] ra;
    logic [REG_W-1:0] rb;
    logic [REG_W-1:0] rc;
    logic [ILEN-1:0]  imm;
    logic [ILEN-1:0]  pc;
    logic             alu_en;
    logic [2:0]       alu_op;
    logic             mem_rd;
    logic             mem_wr;
    logic             reg_wr;
    logic [REG_W-1:0] dest;
    logic             branch;
    logic             jump;
    logic [1:0]       cz;
    logic             cmp;
  } uop_t;
  localparam int UOP_W = $bits(uop_t);
  function automatic cls_t op_class(input logic [3:0] op);
    return op inside {OP_ADD, OP_NDU} ? CLS_R :
           op inside {OP_ADI, OP_LW, OP_SW, OP_BEQ, OP_BLT} ? CLS_I :
           op inside {OP_LHI, OP_LM, OP_SM, OP_JAL, OP_JLR, OP_JRI} ? CLS_J : CLS_NONE;
  endfunction
endpackage

// File: rtl/decode_stage_nw_uop.sv
// uop_decoder: combinational decode of one instruction slot into a uop_t.
// Ports: vld (slot valid), instr, pc in; uop out (all-zero when vld=0).
// Carry/zero predicates are not evaluated here: cz and cmp are passed through raw.
module uop_decoder
  import decode_pkg::*;
(
  input  logic             vld,
  input  logic [ILEN-1:0]  instr,
  input  logic [ILEN-1:0]  pc,
  output logic [UOP_W-1:0] uop
);
  logic [3:0] op;
  cls_t cls;
  uop_t u;
  assign op = instr[15:12];
  assign cls = op_class(op);
  always_comb begin
    u = '0;
    u.opcode = op;
    u.ra = instr[11:9];
    u.rb = instr[8:6];
    u.rc = instr[5:3];
    u.cmp = instr[2];
    u.cz = instr[1:0];
    u.pc = pc;
    u.imm = cls == CLS_I ? {{10{instr[5]}}, instr[5:0]} :
            op == OP_LHI ? {instr[8:0], 7'b0} :
            cls == CLS_J ? {{7{instr[8]}}, instr[8:0]} : '0;
    u.alu_en = cls == CLS_R || op inside {OP_ADI, OP_LW, OP_SW, OP_BEQ, OP_BLT, OP_LHI};
    u.alu_op = op == OP_NDU ? ALU_NAND : op == OP_BEQ ? ALU_SUB : op == OP_BLT ? ALU_SLT :
               op == OP_LHI ? ALU_PASS : ALU_ADD;
    u.mem_rd = op == OP_LW || op == OP_LM;
    u.mem_wr = op == OP_SW || op == OP_SM;
    u.branch = op == OP_BEQ || op == OP_BLT;
    u.jump = op inside {OP_JAL, OP_JLR, OP_JRI};
    // the all-zero word is a NOP even though it carries the ADI opcode
    u.reg_wr = instr != '0 && (cls == CLS_R || op inside {OP_ADI, OP_LW, OP_LHI, OP_JAL, OP_JLR});
    u.dest = !u.reg_wr ? '0 : cls == CLS_R ? instr[5:3] : op == OP_ADI ? instr[8:6] : instr[11:9];
  end
  assign uop = vld ? u : '0;
endmodule

// File: rtl/decode_stage_nw.sv
// decode_stage_nw: WIDTH-slot decode stage with a one-group output register and intra-group dependency bits.
// Ports: clk, rst (sync, active high), flush; in_valid/in_ready/in_slot_vld/in_instr/in_pc from fetch;
//        out_valid/out_ready/out_slot_vld/out_uop/out_dep to rename.
// out_dep bit j*WIDTH+i: slot j reads the destination written by older slot i.
// Build option DECODE_STAGE_SKID_EN: registered in_ready plus a one-group skid buffer.
module decode_stage_nw
  import decode_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int XLEN = 16,
  parameter int NREG = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_slot_vld,
  input  logic [WIDTH*XLEN-1:0]  in_instr,
  input  logic [WIDTH*XLEN-1:0]  in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_slot_vld,
  output logic [WIDTH*UOP_W-1:0] out_uop,
  output logic [WIDTH*WIDTH-1:0] out_dep
);
  localparam int RB = $clog2(NREG);
  if (XLEN != ILEN || RB != REG_W) begin : g_cfg
    $error("decode_pkg uop fields are fixed to XLEN=16 and NREG=8");
  end
  logic [WIDTH*UOP_W-1:0] dec;
  logic [WIDTH*WIDTH-1:0] dep;
  logic acc, drain;
  for (genvar i = 0; i < WIDTH; i++) begin : g_dec
    uop_decoder u_dec (
      .vld(in_slot_vld[i]),
      .instr(in_instr[i*XLEN +: XLEN]),
      .pc(in_pc[i*XLEN +: XLEN]),
      .uop(dec[i*UOP_W +: UOP_W])
    );
  end
  for (genvar j = 0; j < WIDTH; j++) begin : g_j
    for (genvar i = 0; i < WIDTH; i++) begin : g_i
      if (i < j) begin : g_lt
        uop_t p, c;
        assign p = dec[i*UOP_W +: UOP_W];
        assign c = dec[j*UOP_W +: UOP_W];
        // rc is only a source operand for R-type consumers
        assign dep[j*WIDTH+i] = in_slot_vld[i] && in_slot_vld[j] && p.reg_wr && p.dest != '0 &&
                                (p.dest == c.ra || p.dest == c.rb || (op_class(c.opcode) == CLS_R && p.dest == c.rc));
      end else begin : g_ge
        assign dep[j*WIDTH+i] = 1'b0;
      end
    end
  end
  assign acc = in_valid && in_ready;
  assign drain = !out_valid || out_ready;
`ifdef DECODE_STAGE_SKID_EN
  logic skid_vld, skid_nxt;
  logic [WIDTH-1:0] skid_slot;
  logic [WIDTH*UOP_W-1:0] skid_uop;
  logic [WIDTH*WIDTH-1:0] skid_dep;
  // a group is accepted only while the skid is empty, so skid and accept never compete for the output
  assign skid_nxt = !drain && (skid_vld || acc);
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_slot_vld <= '0;
      out_uop <= '0;
      out_dep <= '0;
      skid_vld <= 1'b0;
      skid_slot <= '0;
      skid_uop <= '0;
      skid_dep <= '0;
      in_ready <= 1'b1;
    end else if (flush) begin
      out_valid <= 1'b0;
      skid_vld <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      skid_vld <= skid_nxt;
      in_ready <= !skid_nxt;
      if (drain) out_valid <= skid_vld || acc;
      if (drain && skid_vld) {out_slot_vld, out_uop, out_dep} <= {skid_slot, skid_uop, skid_dep};
      else if (drain && acc) {out_slot_vld, out_uop, out_dep} <= {in_slot_vld, dec, dep};
      if (!drain && acc) {skid_slot, skid_uop, skid_dep} <= {in_slot_vld, dec, dep};
    end
  end
`else
  assign in_ready = drain;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_slot_vld <= '0;
      out_uop <= '0;
      out_dep <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (drain) begin
      out_valid <= acc;
      if (acc) {out_slot_vld, out_uop, out_dep} <= {in_slot_vld, dec, dep};
    end
  end
`endif
endmodule

// File: tb/tb_decode_stage_nw.sv
// tb_decode_stage_nw: self-checking bench for decode_stage_nw (WIDTH=2 and WIDTH=4 instances).
module tb_decode_stage_nw;
  import decode_pkg::*;
  typedef struct packed {
    logic [1:0]         sv;
    logic [2*UOP_W-1:0] u;
    logic [3:0]         d;
  } grp_t;
  logic clk = 0, rst = 1, flush = 0;
  logic v2 = 0, rdy2, ov2, ordy2 = 1;
  logic [1:0] sv2 = '0, osv2;
  logic [31:0] ins2 = '0, pc2 = '0;
  logic [2*UOP_W-1:0] ou2;
  logic [3:0] od2;
  logic v4 = 0, rdy4, ov4;
  logic [3:0] sv4 = '0, osv4;
  logic [63:0] ins4 = '0, pc4 = '0;
  logic [4*UOP_W-1:0] ou4;
  logic [15:0] od4;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  decode_stage_nw #(.WIDTH(2)) d2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(v2), .in_ready(rdy2), .in_slot_vld(sv2),
    .in_instr(ins2), .in_pc(pc2), .out_valid(ov2), .out_ready(ordy2), .out_slot_vld(osv2),
    .out_uop(ou2), .out_dep(od2)
  );
  decode_stage_nw #(.WIDTH(4)) d4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(v4), .in_ready(rdy4), .in_slot_vld(sv4),
    .in_instr(ins4), .in_pc(pc4), .out_valid(ov4), .out_ready(1'b1), .out_slot_vld(osv4),
    .out_uop(ou4), .out_dep(od4)
  );
  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1);
  end
  function automatic uop_t ref_uop(logic v, logic [15:0] ins, logic [15:0] pc);
    uop_t u;
    u = '0;
    if (!v) return u;
    u.opcode = ins[15:12];
    u.ra = ins[11:9];
    u.rb = ins[8:6];
    u.rc = ins[5:3];
    u.cmp = ins[2];
    u.cz = ins[1:0];
    u.pc = pc;
    case (u.opcode)
      4'h1: begin u.alu_en = 1; u.reg_wr = 1; u.dest = u.rc; end
      4'h2: begin u.alu_en = 1; u.alu_op = ALU_NAND; u.reg_wr = 1; u.dest = u.rc; end
      4'h0: begin u.alu_en = 1; u.imm = 16'($signed(ins[5:0])); u.reg_wr = ins != 0; u.dest = u.rb; end
      4'h4: begin u.alu_en = 1; u.imm = 16'($signed(ins[5:0])); u.mem_rd = 1; u.reg_wr = 1; u.dest = u.ra; end
      4'h5: begin u.alu_en = 1; u.imm = 16'($signed(ins[5:0])); u.mem_wr = 1; end
      4'h8: begin u.alu_en = 1; u.alu_op = ALU_SUB; u.imm = 16'($signed(ins[5:0])); u.branch = 1; end
      4'h9: begin u.alu_en = 1; u.alu_op = ALU_SLT; u.imm = 16'($signed(ins[5:0])); u.branch = 1; end
      4'h3: begin u.alu_en = 1; u.alu_op = ALU_PASS; u.imm = 16'(ins[8:0]) * 16'd128; u.reg_wr = 1; u.dest = u.ra; end
      4'h6: begin u.imm = 16'($signed(ins[8:0])); u.mem_rd = 1; end
      4'h7: begin u.imm = 16'($signed(ins[8:0])); u.mem_wr = 1; end
      4'hC, 4'hD: begin u.imm = 16'($signed(ins[8:0])); u.jump = 1; u.reg_wr = 1; u.dest = u.ra; end
      4'hF: begin u.imm = 16'($signed(ins[8:0])); u.jump = 1; end
      default: ;
    endcase
    return u;
  endfunction
  function automatic logic [4*UOP_W-1:0] ref_uops(logic [3:0] sv, logic [63:0] ins, logic [63:0] pc);
    logic [4*UOP_W-1:0] r;
    for (int s = 0; s < 4; s++) r[s*UOP_W +: UOP_W] = ref_uop(sv[s], ins[s*16 +: 16], pc[s*16 +: 16]);
    return r;
  endfunction
  function automatic logic [15:0] ref_dep(int w, logic [3:0] sv, logic [63:0] ins);
    logic [15:0] d;
    d = '0;
    for (int j = 1; j < w; j++)
      for (int i = 0; i < j; i++) begin
        uop_t p, c;
        p = ref_uop(sv[i], ins[i*16 +: 16], 16'h0);
        c = ref_uop(sv[j], ins[j*16 +: 16], 16'h0);
        if (sv[i] && sv[j] && p.reg_wr && p.dest != 0 &&
            (p.dest == c.ra || p.dest == c.rb || ((c.opcode == 4'h1 || c.opcode == 4'h2) && p.dest == c.rc)))
          d[j*w+i] = 1'b1;
      end
    return d;
  endfunction
  function automatic grp_t ref_grp2(logic [1:0] sv, logic [31:0] ins, logic [31:0] pc);
    logic [4*UOP_W-1:0] u;
    logic [15:0] d;
    u = ref_uops({2'b0, sv}, {32'b0, ins}, {32'b0, pc});
    d = ref_dep(2, {2'b0, sv}, {32'b0, ins});
    return '{sv: sv, u: u[2*UOP_W-1:0], d: d[3:0]};
  endfunction
  function automatic grp_t got2();
    return '{sv: osv2, u: ou2, d: od2};
  endfunction
  task automatic rand2();
    sv2 = 2'($urandom_range(1, 3));
    ins2 = $urandom;
    pc2 = $urandom;
    v2 = 1;
  endtask
  task automatic idle();
    @(posedge clk);
    #1 v2 = 0; v4 = 0; ordy2 = 1; flush = 0;
    repeat (3) @(posedge clk);
  endtask
  task automatic test_reset();
    rst = 1; ordy2 = 0; rand2();
    repeat (3) @(posedge clk);
    #1 rst = 0; v2 = 0; ordy2 = 1;
    @(negedge clk);
    checks++; if (ov2 !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", ov2); end
    checks++; if (osv2 !== 2'b0) begin failures++; $display("FAIL reset_slot_vld got=%b exp=0", osv2); end
    checks++; if (ou2 !== '0) begin failures++; $display("FAIL reset_uop got=%h exp=0", ou2); end
    checks++; if (od2 !== 4'b0) begin failures++; $display("FAIL reset_dep got=%b exp=0", od2); end
    checks++; if (rdy2 !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", rdy2); end
    checks++; if (ov4 !== 1'b0 || od4 !== 16'h0) begin failures++; $display("FAIL reset_w4 got=%b/%h exp=0/0", ov4, od4); end
  endtask
  task automatic test_dep_basic();
    grp_t e;
    uop_t s1;
    @(posedge clk);
    #1 sv2 = 2'b11; ins2 = {16'h0741, 16'h1298}; pc2 = {16'h0102, 16'h0100}; v2 = 1;
    e = ref_grp2(sv2, ins2, pc2);
    @(negedge clk);
    checks++; if (rdy2 !== 1'b1) begin failures++; $display("FAIL dep_in_ready got=%b exp=1", rdy2); end
    @(posedge clk);
    #1 v2 = 0;
    @(negedge clk);
    s1 = ou2[UOP_W +: UOP_W];
    checks++; if (ov2 !== 1'b1) begin failures++; $display("FAIL dep_latency got=%b exp=1", ov2); end
    checks++; if (od2 !== 4'b0100) begin failures++; $display("FAIL dep_bits got=%b exp=0100", od2); end
    checks++; if (s1.reg_wr !== 1'b1 || s1.dest !== 3'd5) begin failures++; $display("FAIL dep_slot1 got=%b/%0d exp=1/5", s1.reg_wr, s1.dest); end
    checks++; if (got2() !== e) begin failures++; $display("FAIL dep_group got=%h exp=%h", got2(), e); end
  endtask
  task automatic test_dest_r0();
    grp_t e;
    @(posedge clk);
    #1 sv2 = 2'b11; ins2 = {16'h1020, 16'h0205}; pc2 = $urandom; v2 = 1;
    e = ref_grp2(sv2, ins2, pc2);
    @(posedge clk);
    #1 v2 = 0;
    @(negedge clk);
    checks++; if (ov2 !== 1'b1 || od2 !== 4'b0) begin failures++; $display("FAIL r0_dep got=%b/%b exp=1/0000", ov2, od2); end
    checks++; if (got2() !== e) begin failures++; $display("FAIL r0_group got=%h exp=%h", got2(), e); end
  endtask
  task automatic test_backpressure();
    grp_t a, b;
    int nacc;
    logic ac;
    nacc = 0;
    @(posedge clk);
    #1 ordy2 = 0; rand2(); a = ref_grp2(sv2, ins2, pc2); b = a;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      ac = v2 && rdy2;
      nacc += int'(ac);
      if (c > 0) begin
        checks++; if (ov2 !== 1'b1 || got2() !== a) begin failures++; $display("FAIL bp_hold got=%b/%h exp=1/%h", ov2, got2(), a); end
      end
      @(posedge clk);
      #1;
      if (ac && nacc == 1) begin rand2(); b = ref_grp2(sv2, ins2, pc2); end
      else if (ac) v2 = 0;
    end
`ifdef DECODE_STAGE_SKID_EN
    checks++; if (nacc != 2) begin failures++; $display("FAIL bp_accepted got=%0d exp=2", nacc); end
`else
    checks++; if (nacc != 1) begin failures++; $display("FAIL bp_accepted got=%0d exp=1", nacc); end
`endif
    checks++; if (rdy2 !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", rdy2); end
    ordy2 = 1;
    @(negedge clk);
    checks++; if (ov2 !== 1'b1 || got2() !== a) begin failures++; $display("FAIL bp_first got=%h exp=%h", got2(), a); end
    ac = v2 && rdy2;
    @(posedge clk);
    #1 if (ac) v2 = 0;
    @(negedge clk);
    checks++; if (ov2 !== 1'b1 || got2() !== b) begin failures++; $display("FAIL bp_second got=%b/%h exp=1/%h", ov2, got2(), b); end
    @(posedge clk);
    #1 v2 = 0;
    @(negedge clk);
    checks++; if (ov2 !== 1'b0) begin failures++; $display("FAIL bp_empty got=%b exp=0", ov2); end
  endtask
  task automatic test_flush();
    grp_t a;
    @(posedge clk);
    #1 ordy2 = 0; rand2(); a = ref_grp2(sv2, ins2, pc2);
    @(posedge clk);
    #1 rand2();
    @(posedge clk);
    #1 flush = 1; rand2();
    @(negedge clk);
    checks++; if (ov2 !== 1'b1 || got2() !== a) begin failures++; $display("FAIL flush_pre got=%b/%h exp=1/%h", ov2, got2(), a); end
`ifdef DECODE_STAGE_SKID_EN
    checks++; if (rdy2 !== 1'b0) begin failures++; $display("FAIL flush_skid_full got=%b exp=0", rdy2); end
`endif
    @(posedge clk);
    #1 flush = 0; v2 = 0; ordy2 = 1;
    @(negedge clk);
    checks++; if (ov2 !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", ov2); end
    checks++; if (rdy2 !== 1'b1) begin failures++; $display("FAIL flush_ready got=%b exp=1", rdy2); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (ov2 !== 1'b0) begin failures++; $display("FAIL flush_stale got=%b exp=0", ov2); end
    end
    @(posedge clk);
    #1 flush = 1; rand2();
    @(negedge clk);
    checks++; if (rdy2 !== 1'b1) begin failures++; $display("FAIL flush_offer_ready got=%b exp=1", rdy2); end
    @(posedge clk);
    #1 flush = 0; v2 = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (ov2 !== 1'b0) begin failures++; $display("FAIL flush_discard got=%b exp=0", ov2); end
    end
  endtask
  task automatic test_width4();
    logic [4*UOP_W-1:0] eu;
    logic [15:0] ed;
    @(posedge clk);
    #1 sv4 = 4'b1011; ins4 = {16'h2738, 16'h16E8, 16'h0F82, 16'h1298}; pc4 = {$urandom, $urandom}; v4 = 1;
    eu = ref_uops(sv4, ins4, pc4);
    ed = ref_dep(4, sv4, ins4);
    @(negedge clk);
    checks++; if (rdy4 !== 1'b1) begin failures++; $display("FAIL w4_ready got=%b exp=1", rdy4); end
    @(posedge clk);
    #1 v4 = 0;
    @(negedge clk);
    checks++; if (ov4 !== 1'b1 || osv4 !== 4'b1011) begin failures++; $display("FAIL w4_valid got=%b/%b exp=1/1011", ov4, osv4); end
    checks++; if (ou4[2*UOP_W +: UOP_W] !== '0) begin failures++; $display("FAIL w4_slot2 got=%h exp=0", ou4[2*UOP_W +: UOP_W]); end
    checks++; if (od4 !== 16'h1000) begin failures++; $display("FAIL w4_dep got=%h exp=1000", od4); end
    checks++; if (ou4 !== eu || od4 !== ed) begin failures++; $display("FAIL w4_group got=%h/%h exp=%h/%h", ou4, od4, eu, ed); end
  endtask
  task automatic test_stream();
    grp_t e[$];
    grp_t x;
    ordy2 = 1;
    for (int i = 0; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (i < 100) begin rand2(); e.push_back(ref_grp2(sv2, ins2, pc2)); end
      else v2 = 0;
      @(negedge clk);
      if (i > 0) begin
        x = e.pop_front();
        checks++; if (ov2 !== 1'b1 || got2() !== x) begin failures++; $display("FAIL stream_%0d got=%b/%h exp=1/%h", i - 1, ov2, got2(), x); end
      end
      if (i < 100) begin
        checks++; if (rdy2 !== 1'b1) begin failures++; $display("FAIL stream_ready_%0d got=%b exp=1", i, rdy2); end
      end
    end
  endtask
  task automatic test_back_to_back();
    grp_t q[$];
    grp_t f;
    logic took;
    took = 1;
    for (int c = 0; c < 320; c++) begin
      @(posedge clk);
      #1;
      if (c >= 300) begin v2 = 0; ordy2 = 1; end
      else begin
        if (took || !v2) begin
          if ($urandom_range(0, 3) != 0) rand2();
          else v2 = 0;
        end
        ordy2 = $urandom_range(0, 2) != 0;
      end
      @(negedge clk);
      f = q.size() != 0 ? q[0] : '0;
      if (ov2) begin
        checks++; if (q.size() == 0 || got2() !== f) begin failures++; $display("FAIL b2b_order_%0d got=%h exp=%h", c, got2(), f); end
      end else begin
        checks++; if (q.size() != 0) begin failures++; $display("FAIL b2b_bubble_%0d got=0 exp=1", c); end
      end
      if (ov2 && ordy2 && q.size() != 0) void'(q.pop_front());
      took = v2 && rdy2;
      if (took) q.push_back(ref_grp2(sv2, ins2, pc2));
    end
    checks++; if (q.size() != 0) begin failures++; $display("FAIL b2b_drain got=%0d exp=0", q.size()); end
  endtask
  initial begin
    test_reset();
    test_dep_basic();
    idle();
    test_dest_r0();
    idle();
    test_backpressure();
    idle();
    test_flush();
    idle();
    test_width4();
    test_stream();
    idle();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
